// File: rtl/tomasulo_rs.sv
`default_nettype none
// ============================================================================
// Module      : tomasulo_rs
// Description : Reservation station in front of the execution unit. Holds
//               dispatched ops until both operands are valid, snoops the CDB
//               for operand values, and issues the oldest ready op (or the
//               lowest-index ready op when AGE_EN=0) once per cycle.
//               Optional feature macro: TOMASULO_RS_CDB_BYPASS_EN -- when
//               defined, an operand woken by the CDB is selectable in the
//               same cycle, with the CDB data muxed into the issue register.
// Revision    : 1.0 - initial release
// ============================================================================
module tomasulo_rs #(
    parameter int N       = 4,
    parameter int AGE_EN  = 1,
    parameter int OP_W    = 4,
    parameter int IMM_W   = 16,
    parameter int WORD_W  = 32,
    parameter int TAG_W   = 4,
    parameter int ROBID_W = 4,
    parameter int WA_W    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    // Dispatch side
    input  logic                  dis_vld,
    output logic                  dis_rdy,
    input  logic [OP_W-1:0]       dis_op,
    input  logic [IMM_W-1:0]      dis_imm,
    input  logic [TAG_W-1:0]      dis_tag,
    input  logic [ROBID_W-1:0]    dis_robid,
    input  logic [WA_W-1:0]       dis_wa,
    input  logic [1:0]            dis_src_rdy,
    input  logic [2*TAG_W-1:0]    dis_src_tag,   // [TAG_W-1:0] is operand 0
    input  logic [2*WORD_W-1:0]   dis_src_data,  // [WORD_W-1:0] is operand 0
    // Common data bus
    input  logic                  cdb_vld,
    input  logic [TAG_W-1:0]      cdb_tag,
    input  logic [WORD_W-1:0]     cdb_wdata,
    input  logic [ROBID_W-1:0]    cdb_robid,
    input  logic [WA_W-1:0]       cdb_wa,
    // Issue side
    output logic                  iss_vld,
    output logic [OP_W-1:0]       iss_op,
    output logic [2*WORD_W-1:0]   iss_rdata,     // {rdata[1], rdata[0]}
    output logic [IMM_W-1:0]      iss_imm,
    output logic [TAG_W-1:0]      iss_tag,
    output logic [ROBID_W-1:0]    iss_robid,
    output logic [WA_W-1:0]       iss_wa
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    // ------------------------------------------------------------------
    // Entry state
    // ------------------------------------------------------------------
    logic [N-1:0]        vld_q,   vld_d;
    logic [OP_W-1:0]     op_q    [N];
    logic [OP_W-1:0]     op_d    [N];
    logic [IMM_W-1:0]    imm_q   [N];
    logic [IMM_W-1:0]    imm_d   [N];
    logic [TAG_W-1:0]    rtag_q  [N];
    logic [TAG_W-1:0]    rtag_d  [N];
    logic [ROBID_W-1:0]  robid_q [N];
    logic [ROBID_W-1:0]  robid_d [N];
    logic [WA_W-1:0]     wa_q    [N];
    logic [WA_W-1:0]     wa_d    [N];
    logic [1:0]          srdy_q  [N];
    logic [1:0]          srdy_d  [N];
    logic [TAG_W-1:0]    stag_q  [N][2];
    logic [TAG_W-1:0]    stag_d  [N][2];
    logic [WORD_W-1:0]   sdata_q [N][2];
    logic [WORD_W-1:0]   sdata_d [N][2];
    // age_q[i][j] = 1 means entry j is older than entry i
    logic [N-1:0]        age_q   [N];
    logic [N-1:0]        age_d   [N];
    logic                init_q,  init_d;

    // Issue register
    logic                iss_vld_q,   iss_vld_d;
    logic [OP_W-1:0]     iss_op_q,    iss_op_d;
    logic [2*WORD_W-1:0] iss_rdata_q, iss_rdata_d;
    logic [IMM_W-1:0]    iss_imm_q,   iss_imm_d;
    logic [TAG_W-1:0]    iss_tag_q,   iss_tag_d;
    logic [ROBID_W-1:0]  iss_robid_q, iss_robid_d;
    logic [WA_W-1:0]     iss_wa_q,    iss_wa_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [1:0]          w_wake      [N];
    logic [1:0]          w_opnd_rdy  [N];
    logic [WORD_W-1:0]   w_opnd_data [N][2];
    logic [N-1:0]        w_ready;
    logic [N-1:0]        w_sel;
    logic                w_iss_any;
    logic [IDX_W-1:0]    w_iss_idx;
    logic [IDX_W-1:0]    w_alloc_idx;
    logic                w_free_found;
    logic                w_alloc;
    logic                cdb_unused;

    // The RS only needs tag and data from the CDB
    assign cdb_unused = ^{cdb_robid, cdb_wa};

    // Dispatch is allowed once reset has been released and an entry is free
    assign dis_rdy = init_q & ~(&vld_q);
    assign w_alloc = dis_vld & dis_rdy;
    assign init_d  = 1'b1;

    // CDB tag match per waiting operand and the operand view used by select
    always_comb begin
        w_ready = '0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 2; k++) begin
                w_wake[i][k] = cdb_vld & vld_q[i] & ~srdy_q[i][k] &
                               (stag_q[i][k] == cdb_tag);
`ifdef TOMASULO_RS_CDB_BYPASS_EN
                w_opnd_rdy[i][k]  = srdy_q[i][k] | w_wake[i][k];
                w_opnd_data[i][k] = w_wake[i][k] ? cdb_wdata : sdata_q[i][k];
`else
                w_opnd_rdy[i][k]  = srdy_q[i][k];
                w_opnd_data[i][k] = sdata_q[i][k];
`endif
            end
            w_ready[i] = vld_q[i] & (&w_opnd_rdy[i]);
        end
    end

    // Select one ready entry: oldest by age matrix, or lowest index
    generate
        if (AGE_EN != 0) begin : g_age_sel
            for (genvar i = 0; i < N; i++) begin : g_ent
                assign w_sel[i] = w_ready[i] & ~|(age_q[i] & w_ready);
            end
        end else begin : g_idx_sel
            for (genvar i = 0; i < N; i++) begin : g_ent
                localparam logic [N-1:0] LOWER = N'((64'd1 << i) - 64'd1);
                assign w_sel[i] = w_ready[i] & ~|(w_ready & LOWER);
            end
        end
    endgenerate

    // Encode the one-hot select and find the lowest free entry
    always_comb begin
        w_iss_any    = |w_sel;
        w_iss_idx    = '0;
        w_alloc_idx  = '0;
        w_free_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (w_sel[i]) begin
                w_iss_idx = IDX_W'(i);
            end
            if (!vld_q[i] && !w_free_found) begin
                w_alloc_idx  = IDX_W'(i);
                w_free_found = 1'b1;
            end
        end
    end

    // Entry update: CDB capture, free on issue, allocate on dispatch
    always_comb begin
        vld_d   = vld_q;
        op_d    = op_q;
        imm_d   = imm_q;
        rtag_d  = rtag_q;
        robid_d = robid_q;
        wa_d    = wa_q;
        srdy_d  = srdy_q;
        stag_d  = stag_q;
        sdata_d = sdata_q;
        age_d   = age_q;

        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (w_wake[i][k]) begin
                    srdy_d[i][k]  = 1'b1;
                    sdata_d[i][k] = cdb_wdata;
                end
            end
        end

        // The issuing entry leaves; nobody may consider it older any more
        if (w_iss_any) begin
            vld_d[w_iss_idx] = 1'b0;
            for (int i = 0; i < N; i++) begin
                age_d[i][w_iss_idx] = 1'b0;
            end
        end

        // The allocated index comes from registered state, so it can never
        // be the entry that is issuing this cycle.
        if (w_alloc) begin
            vld_d[w_alloc_idx]   = 1'b1;
            op_d[w_alloc_idx]    = dis_op;
            imm_d[w_alloc_idx]   = dis_imm;
            rtag_d[w_alloc_idx]  = dis_tag;
            robid_d[w_alloc_idx] = dis_robid;
            wa_d[w_alloc_idx]    = dis_wa;
            age_d[w_alloc_idx]   = vld_q & ~w_sel;
            for (int k = 0; k < 2; k++) begin
                stag_d[w_alloc_idx][k] = dis_src_tag[k*TAG_W +: TAG_W];
                if (dis_src_rdy[k]) begin
                    srdy_d[w_alloc_idx][k]  = 1'b1;
                    sdata_d[w_alloc_idx][k] = dis_src_data[k*WORD_W +: WORD_W];
                end else if (cdb_vld && (cdb_tag == dis_src_tag[k*TAG_W +: TAG_W])) begin
                    // Producer completes in the dispatch cycle itself
                    srdy_d[w_alloc_idx][k]  = 1'b1;
                    sdata_d[w_alloc_idx][k] = cdb_wdata;
                end else begin
                    srdy_d[w_alloc_idx][k]  = 1'b0;
                    sdata_d[w_alloc_idx][k] = '0;
                end
            end
        end
    end

    // Issue register: load the selected entry, otherwise hold the payload
    always_comb begin
        iss_vld_d   = w_iss_any;
        iss_op_d    = iss_op_q;
        iss_rdata_d = iss_rdata_q;
        iss_imm_d   = iss_imm_q;
        iss_tag_d   = iss_tag_q;
        iss_robid_d = iss_robid_q;
        iss_wa_d    = iss_wa_q;
        if (w_iss_any) begin
            iss_op_d    = op_q[w_iss_idx];
            iss_rdata_d = {w_opnd_data[w_iss_idx][1], w_opnd_data[w_iss_idx][0]};
            iss_imm_d   = imm_q[w_iss_idx];
            iss_tag_d   = rtag_q[w_iss_idx];
            iss_robid_d = robid_q[w_iss_idx];
            iss_wa_d    = wa_q[w_iss_idx];
        end
    end

    // Control state and issue register, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= '0;
            init_q      <= 1'b0;
            iss_vld_q   <= 1'b0;
            iss_op_q    <= '0;
            iss_rdata_q <= '0;
            iss_imm_q   <= '0;
            iss_tag_q   <= '0;
            iss_robid_q <= '0;
            iss_wa_q    <= '0;
            for (int i = 0; i < N; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            vld_q       <= vld_d;
            init_q      <= init_d;
            iss_vld_q   <= iss_vld_d;
            iss_op_q    <= iss_op_d;
            iss_rdata_q <= iss_rdata_d;
            iss_imm_q   <= iss_imm_d;
            iss_tag_q   <= iss_tag_d;
            iss_robid_q <= iss_robid_d;
            iss_wa_q    <= iss_wa_d;
            age_q       <= age_d;
        end
    end

    // Entry payload is only observed through valid entries, so no reset
    always_ff @(posedge clk) begin
        op_q    <= op_d;
        imm_q   <= imm_d;
        rtag_q  <= rtag_d;
        robid_q <= robid_d;
        wa_q    <= wa_d;
        srdy_q  <= srdy_d;
        stag_q  <= stag_d;
        sdata_q <= sdata_d;
    end

    assign iss_vld   = iss_vld_q;
    assign iss_op    = iss_op_q;
    assign iss_rdata = iss_rdata_q;
    assign iss_imm   = iss_imm_q;
    assign iss_tag   = iss_tag_q;
    assign iss_robid = iss_robid_q;
    assign iss_wa    = iss_wa_q;

endmodule
`default_nettype wire

// File: tb/tb_tomasulo_rs.sv
`default_nettype none
// ============================================================================
// Module      : tb_tomasulo_rs
// Description : Self-checking bench for tomasulo_rs (N=4, AGE_EN=1). A table
//               of per-cycle vectors plus directed multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tomasulo_rs;

    localparam int N = 4, OP_W = 4, IMM_W = 16, WORD_W = 32, TAG_W = 4, ROBID_W = 4, WA_W = 5;
`ifdef TOMASULO_RS_CDB_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif
    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                dis_vld, dis_rdy;
    logic [OP_W-1:0]     dis_op;
    logic [IMM_W-1:0]    dis_imm;
    logic [TAG_W-1:0]    dis_tag;
    logic [ROBID_W-1:0]  dis_robid;
    logic [WA_W-1:0]     dis_wa;
    logic [1:0]          dis_src_rdy;
    logic [2*TAG_W-1:0]  dis_src_tag;
    logic [2*WORD_W-1:0] dis_src_data;
    logic                cdb_vld;
    logic [TAG_W-1:0]    cdb_tag;
    logic [WORD_W-1:0]   cdb_wdata;
    logic [ROBID_W-1:0]  cdb_robid;
    logic [WA_W-1:0]     cdb_wa;
    logic                iss_vld;
    logic [OP_W-1:0]     iss_op;
    logic [2*WORD_W-1:0] iss_rdata;
    logic [IMM_W-1:0]    iss_imm;
    logic [TAG_W-1:0]    iss_tag;
    logic [ROBID_W-1:0]  iss_robid;
    logic [WA_W-1:0]     iss_wa;

    tomasulo_rs #(
        .N(N), .AGE_EN(1), .OP_W(OP_W), .IMM_W(IMM_W), .WORD_W(WORD_W),
        .TAG_W(TAG_W), .ROBID_W(ROBID_W), .WA_W(WA_W)
    ) dut (
        .clk(clk), .rst(rst),
        .dis_vld(dis_vld), .dis_rdy(dis_rdy), .dis_op(dis_op), .dis_imm(dis_imm),
        .dis_tag(dis_tag), .dis_robid(dis_robid), .dis_wa(dis_wa),
        .dis_src_rdy(dis_src_rdy), .dis_src_tag(dis_src_tag), .dis_src_data(dis_src_data),
        .cdb_vld(cdb_vld), .cdb_tag(cdb_tag), .cdb_wdata(cdb_wdata),
        .cdb_robid(cdb_robid), .cdb_wa(cdb_wa),
        .iss_vld(iss_vld), .iss_op(iss_op), .iss_rdata(iss_rdata), .iss_imm(iss_imm),
        .iss_tag(iss_tag), .iss_robid(iss_robid), .iss_wa(iss_wa)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        dvld;
        logic [3:0]  op;
        logic [3:0]  tag;
        logic [1:0]  srdy;
        logic [3:0]  stag0;
        logic [3:0]  stag1;
        logic [31:0] sd0;
        logic [31:0] sd1;
        logic        cvld;
        logic [3:0]  ctag;
        logic [31:0] cdata;
        logic        e_iss;
        logic        e_rdy;
        logic        chk_iss;
        logic [3:0]  e_tag;
        logic [63:0] e_rdata;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        dis_vld = 1'b0; dis_op = '0; dis_imm = '0; dis_tag = '0; dis_robid = '0;
        dis_wa = '0; dis_src_rdy = '0; dis_src_tag = '0; dis_src_data = '0;
        cdb_vld = 1'b0; cdb_tag = '0; cdb_wdata = '0; cdb_robid = '0; cdb_wa = '0;
    endtask

    // robid mirrors the result tag so the bench can cross-check payload routing
    task automatic set_dis(input logic [3:0] op, input logic [3:0] tag, input logic [1:0] srdy,
                           input logic [3:0] t0, input logic [3:0] t1,
                           input logic [31:0] d0, input logic [31:0] d1);
        dis_vld      = 1'b1;
        dis_op       = op;
        dis_tag      = tag;
        dis_robid    = tag;
        dis_wa       = {1'b0, tag};
        dis_imm      = {12'h0, tag};
        dis_src_rdy  = srdy;
        dis_src_tag  = {t1, t0};
        dis_src_data = {d1, d0};
    endtask

    task automatic set_cdb(input logic [3:0] tag, input logic [31:0] data);
        cdb_vld   = 1'b1;
        cdb_tag   = tag;
        cdb_wdata = data;
    endtask

    function automatic vec_t row(input logic r, input logic ei, input logic er);
        vec_t v;
        v.rst = r; v.dvld = 1'b0; v.op = '0; v.tag = '0; v.srdy = '0;
        v.stag0 = '0; v.stag1 = '0; v.sd0 = '0; v.sd1 = '0;
        v.cvld = 1'b0; v.ctag = '0; v.cdata = '0;
        v.e_iss = ei; v.e_rdy = er; v.chk_iss = 1'b0; v.e_tag = '0; v.e_rdata = '0;
        return v;
    endfunction

    task automatic apply(input vec_t v, input int idx);
        idle_in();
        rst = v.rst;
        if (v.dvld) set_dis(v.op, v.tag, v.srdy, v.stag0, v.stag1, v.sd0, v.sd1);
        if (v.cvld) set_cdb(v.ctag, v.cdata);
        tick();
        check($sformatf("vec%0d_iss_vld", idx), 64'(iss_vld), 64'(v.e_iss));
        check($sformatf("vec%0d_dis_rdy", idx), 64'(dis_rdy), 64'(v.e_rdy));
        if (v.chk_iss) begin
            check($sformatf("vec%0d_iss_tag", idx), 64'(iss_tag), 64'(v.e_tag));
            check($sformatf("vec%0d_iss_robid", idx), 64'(iss_robid), 64'(v.e_tag));
            check($sformatf("vec%0d_iss_rdata", idx), iss_rdata, v.e_rdata);
        end
    endtask

    task automatic wait_iss(input string name, input logic [3:0] exp_tag, input logic [63:0] exp_rdata);
        int c = 0;
        while (!iss_vld && c < 6) begin
            tick();
            c++;
        end
        check({name, "_vld"}, 64'(iss_vld), 64'd1);
        check({name, "_tag"}, 64'(iss_tag), 64'(exp_tag));
        check({name, "_rdata"}, iss_rdata, exp_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vq[$];
        vec_t v;
        logic [3:0] got[$];
        int lat;

        rst = 1'b1;
        idle_in();

        // ---------------- vector table ----------------
        v = row(1, 0, 0); v.chk_iss = 1'b1; vq.push_back(v);          // reset: iss cleared
        v = row(1, 0, 0); vq.push_back(v);
        v = row(0, 0, 1); vq.push_back(v);                            // ready after release
        v = row(0, 0, 1); v.dvld = 1; v.op = OP_AND; v.tag = 4'd5; v.srdy = 2'b11;
        v.sd0 = 32'h0F; v.sd1 = 32'h3C; vq.push_back(v);
        v = row(0, 1, 1); v.chk_iss = 1; v.e_tag = 4'd5; v.e_rdata = {32'h3C, 32'h0F}; vq.push_back(v);
        v = row(0, 0, 1); v.chk_iss = 1; v.e_tag = 4'd5; v.e_rdata = {32'h3C, 32'h0F}; vq.push_back(v);
        // dispatch-time capture: src0 waits on tag 2 that is on the CDB now
        v = row(0, 0, 1); v.dvld = 1; v.op = OP_OR; v.tag = 4'd9; v.srdy = 2'b10; v.stag0 = 4'd2;
        v.sd1 = 32'h11; v.cvld = 1; v.ctag = 4'd2; v.cdata = 32'h77; vq.push_back(v);
        v = row(0, 1, 1); v.chk_iss = 1; v.e_tag = 4'd9; v.e_rdata = {32'h11, 32'h77}; vq.push_back(v);
        v = row(0, 0, 1); vq.push_back(v);
        // fill all four entries waiting on tag 7
        for (int k = 0; k < 4; k++) begin
            v = row(0, 0, (k < 3)); v.dvld = 1; v.op = OP_OR; v.tag = 4'(10 + k);
            v.srdy = 2'b10; v.stag0 = 4'd7; v.sd1 = 32'h100 + 32'(k); vq.push_back(v);
        end
        // dispatch while full is ignored
        v = row(0, 0, 0); v.dvld = 1; v.op = OP_AND; v.tag = 4'd14; v.srdy = 2'b11;
        v.sd0 = 32'hEE; v.sd1 = 32'hEE; vq.push_back(v);
        // tag 7 wakes all four; they drain oldest first on consecutive cycles
        for (int k = 0; k < 6; k++) begin
            int m;
            m = k - 1 + BYP;
            v = row(0, (m >= 0 && m <= 3), (m >= 0));
            if (k == 0) begin
                v.cvld = 1; v.ctag = 4'd7; v.cdata = 32'hBB;
            end
            if (m >= 0 && m <= 3) begin
                v.chk_iss = 1; v.e_tag = 4'(10 + m); v.e_rdata = {32'h100 + 32'(m), 32'hBB};
            end
            vq.push_back(v);
        end

        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i], i);
        end
        idle_in();

        // ---------------- CDB wakeup latency ----------------
        set_dis(OP_OR, 4'd6, 2'b10, 4'd3, 4'd0, 32'h0, 32'h22);
        tick(); idle_in();
        check("wake_after_dispatch_iss_vld", 64'(iss_vld), 64'd0);
        tick();
        check("wake_no_cdb_iss_vld", 64'(iss_vld), 64'd0);
        set_cdb(4'd3, 32'hA5);
        tick(); idle_in();
        lat = 1;
        while (!iss_vld && lat < 5) begin
            tick();
            lat++;
        end
        check("wake_latency", 64'(lat), 64'(2 - BYP));
        check("wake_iss_tag", 64'(iss_tag), 64'd6);
        check("wake_iss_rdata", iss_rdata, {32'h22, 32'hA5});
        tick();
        check("wake_single_issue", 64'(iss_vld), 64'd0);

        // ---------------- age order vs index order ----------------
        set_dis(OP_OR, 4'd1, 2'b10, 4'd8, 4'd0, 32'h0, 32'h1);   // e0, waits 8
        tick();
        set_dis(OP_OR, 4'd2, 2'b10, 4'd10, 4'd0, 32'h0, 32'h2);  // e1, waits 10
        tick();
        set_dis(OP_OR, 4'd3, 2'b10, 4'd9, 4'd0, 32'h0, 32'h3);   // e2, waits 9
        tick(); idle_in();
        set_cdb(4'd8, 32'h80);
        tick(); idle_in();
        wait_iss("age_first", 4'd1, {32'h1, 32'h80});
        set_dis(OP_OR, 4'd4, 2'b10, 4'd9, 4'd0, 32'h0, 32'h4);   // reuses e0, youngest
        tick(); idle_in();
        check("age_three_valid_rdy", 64'(dis_rdy), 64'd1);
        set_cdb(4'd9, 32'h90);                                     // wakes e2 and e0
        tick(); idle_in();
        if (iss_vld) got.push_back(iss_tag);
        set_dis(OP_AND, 4'd5, 2'b11, 4'd0, 4'd0, 32'h5, 32'h5);  // dispatch in the freeing cycle
        tick(); idle_in();
        check("age_dispatch_rdy", 64'(dis_rdy), 64'd1);
        if (iss_vld) got.push_back(iss_tag);
        for (int c = 0; c < 5; c++) begin
            tick();
            if (iss_vld) got.push_back(iss_tag);
        end
        check("age_issue_count", 64'(got.size()), 64'd3);
        for (int j = 0; j < 3; j++) begin
            check($sformatf("age_order%0d", j), 64'((j < got.size()) ? got[j] : 4'hF), 64'(3 + j));
        end

        // ---------------- both operands woken by one broadcast ----------------
        set_dis(OP_AND, 4'd7, 2'b00, 4'd12, 4'd12, 32'h0, 32'h0);
        tick(); idle_in();
        tick();
        check("dual_wait_iss_vld", 64'(iss_vld), 64'd0);
        set_cdb(4'd12, 32'h5A);
        tick(); idle_in();
        wait_iss("dual_wake", 4'd7, {32'h5A, 32'h5A});
        tick();

        // ---------------- reset with three valid entries ----------------
        set_dis(OP_OR, 4'd8, 2'b10, 4'd11, 4'd0, 32'h0, 32'h8);
        tick();
        set_dis(OP_AND, 4'd9, 2'b11, 4'd0, 4'd0, 32'h99, 32'h99);
        tick(); idle_in();
        rst = 1'b1;
        tick();
        check("rst_mid_iss_vld", 64'(iss_vld), 64'd0);
        check("rst_mid_iss_tag", 64'(iss_tag), 64'd0);
        check("rst_mid_dis_rdy", 64'(dis_rdy), 64'd0);
        rst = 1'b0;
        tick();
        check("rst_release_dis_rdy", 64'(dis_rdy), 64'd1);
        check("rst_release_iss_vld", 64'(iss_vld), 64'd0);
        set_cdb(4'd10, 32'hAA);
        tick(); idle_in();
        check("rst_stale_cdb10", 64'(iss_vld), 64'd0);
        set_cdb(4'd11, 32'hAB);
        tick(); idle_in();
        check("rst_stale_cdb11", 64'(iss_vld), 64'd0);
        for (int c = 0; c < 2; c++) begin
            tick();
            check($sformatf("rst_stale_idle%0d", c), 64'(iss_vld), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
